median_frame_ctrl: RTL

Frame sequencer for the median-filter IP. After the AXI register block issues start with width and height, it walks the source image memory in raster order and gathers each pixel's 3x3 neighbourhood (edges replicated). It hands the window to the median core, writes each result to the destination image memory, and reports busy, done and error status back to the register block, which software polls.

---
 rtl/median_frame_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/median_frame_ctrl.sv
// rtl/median_frame_ctrl.sv - raster-scan frame sequencer feeding a 3x3 median core
// Gathers edge-replicated 3x3 windows from source memory and writes medians to destination memory.
module median_frame_ctrl #(
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 10
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               src_re,
  output logic [ADDR_W-1:0]  src_addr,
  input  logic [PIX_W-1:0]   src_rdata,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  input  logic               med_valid,
  input  logic [PIX_W-1:0]   med_data,
  output logic               dst_we,
  output logic [ADDR_W-1:0]  dst_addr,
  output logic [PIX_W-1:0]   dst_wdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_FETCH, S_WAIT_RD, S_SEND, S_WAIT_MED, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [DIM_W-1:0]   ONE_D    = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [2*DIM_W-1:0] MAX_AREA = {{(2*DIM_W-1){1'b0}}, 1'b1} << ADDR_W;

  state_t             r_state;
  state_t             w_next;
  logic [DIM_W-1:0]   r_w, r_h, r_x, r_y;
  logic [3:0]         r_k, r_rd_slot;
  logic               r_rd_pend, r_err;
  logic [9*PIX_W-1:0] r_win;
  logic [PIX_W-1:0]   r_med;

  logic [2*DIM_W-1:0] w_area;
  logic               w_cfg_bad, w_last_x, w_last_y;
  logic [1:0]         w_row, w_col;
  logic [DIM_W-1:0]   w_xc, w_yc;

  assign w_area    = {{DIM_W{1'b0}}, r_w} * {{DIM_W{1'b0}}, r_h};
  assign w_cfg_bad = (r_w == '0) || (r_h == '0) || (w_area > MAX_AREA);
  assign w_last_x  = (r_x == r_w - ONE_D);
  assign w_last_y  = (r_y == r_h - ONE_D);

  // Fetch index k walks the window row-major: row = k/3, col = k%3 (0 => -1, 2 => +1).
  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    case (r_k)
      4'd0: begin w_row = 2'd0; w_col = 2'd0; end
      4'd1: begin w_row = 2'd0; w_col = 2'd1; end
      4'd2: begin w_row = 2'd0; w_col = 2'd2; end
      4'd3: begin w_row = 2'd1; w_col = 2'd0; end
      4'd4: begin w_row = 2'd1; w_col = 2'd1; end
      4'd5: begin w_row = 2'd1; w_col = 2'd2; end
      4'd6: begin w_row = 2'd2; w_col = 2'd0; end
      4'd7: begin w_row = 2'd2; w_col = 2'd1; end
      4'd8: begin w_row = 2'd2; w_col = 2'd2; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  always_comb begin
    w_xc = r_x;
    w_yc = r_y;
    if (w_col == 2'd0 && r_x != '0) w_xc = r_x - ONE_D;
    if (w_col == 2'd2 && !w_last_x) w_xc = r_x + ONE_D;
    if (w_row == 2'd0 && r_y != '0) w_yc = r_y - ONE_D;
    if (w_row == 2'd2 && !w_last_y) w_yc = r_y + ONE_D;
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign src_re    = (r_state == S_FETCH);
  assign src_addr  = ADDR_W'(w_yc) * ADDR_W'(r_w) + ADDR_W'(w_xc);
  assign win_valid = (r_state == S_SEND);
  assign win_data  = r_win;
  assign dst_we    = (r_state == S_WRITE);
  assign dst_addr  = ADDR_W'(r_y) * ADDR_W'(r_w) + ADDR_W'(r_x);
  assign dst_wdata = r_med;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_CHECK;
      S_CHECK:    w_next = w_cfg_bad ? S_DONE : S_FETCH;
      S_FETCH:    if (r_k == 4'd8) w_next = S_WAIT_RD;
      S_WAIT_RD:  w_next = S_SEND;
      S_SEND:     if (win_ready) w_next = S_WAIT_MED;
      S_WAIT_MED: if (med_valid) w_next = S_WRITE;
      S_WRITE:    w_next = S_NEXT;
      S_NEXT:     w_next = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    // Abort also beats a same-cycle start while idle.
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_w       <= '0;
      r_h       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_k       <= '0;
      r_rd_slot <= '0;
      r_rd_pend <= 1'b0;
      r_err     <= 1'b0;
      r_win     <= '0;
      r_med     <= '0;
    end else begin
      r_rd_pend <= (r_state == S_FETCH);
      r_rd_slot <= r_k;
      for (int i = 0; i < 9; i++) begin
        if (r_rd_pend && r_rd_slot == 4'(i)) r_win[i*PIX_W +: PIX_W] <= src_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_w   <= cfg_width;
            r_h   <= cfg_height;
            r_err <= 1'b0;
          end
        end
        S_CHECK: begin
          r_x <= '0;
          r_y <= '0;
          r_k <= '0;
          if (w_cfg_bad && !abort) r_err <= 1'b1;
        end
        S_FETCH:    r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
        S_WAIT_MED: if (med_valid) r_med <= med_data;
        S_NEXT: begin
          if (w_last_x) begin
            r_x <= '0;
            r_y <= r_y + ONE_D;
          end else begin
            r_x <= r_x + ONE_D;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
